// File: rtl/alu_exec_stage.sv
// Execute stage: registered ALU results, persistent CMP/SEE flags, branch resolve, END latch, shift-add MUL.
// Latency: 1 cycle for all ops except MUL, whose product is written DATA_W cycles after acceptance.
// Backpressure: in_ready_o drops while a MUL iterates, after END (until reset) and during reset.
// Ports: clk_i/rst_i; in_valid_i/in_ready_o handshake with op_i, adr_i, a_i, b_i, cnt_i;
//        haz_i -> haz_o (1-cycle delay); wr_ena_o/wr_adr_o/wr_data_o write-back;
//        br_take_o/br_cnt_o branch; flags_o {see,gt,lt,eq}; busy_o (MUL); end_pr_o (sticky END).
module alu_exec_stage #(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 4,
    parameter int CNT_W  = 12,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        op_i,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              haz_i,
    output logic              haz_o,
    output logic              wr_ena_o,
    output logic [ADR_W-1:0]  wr_adr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              br_take_o,
    output logic [CNT_W-1:0]  br_cnt_o,
    output logic [3:0]        flags_o,
    output logic              busy_o,
    output logic              end_pr_o
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [SH_W-1:0] LAST_STEP = SH_W'(DATA_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HALT} state_e;
    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_MOV = 4'h1, OP_CMP = 4'h2, OP_SEE = 4'h3,
        OP_OR  = 4'h4, OP_AND = 4'h5, OP_JMP = 4'h6, OP_JN  = 4'h7,
        OP_INC = 4'h8, OP_DEC = 4'h9, OP_END = 4'hA, OP_JR  = 4'hB,
        OP_SUB = 4'hC, OP_MUL = 4'hD, OP_SHL = 4'hE, OP_SHR = 4'hF
    } op_e;

    state_e            state_q,  state_d;
    logic [DATA_W-1:0] mcand_q,  mcand_d;   // multiplicand, shifted left each step
    logic [DATA_W-1:0] mplier_q, mplier_d;  // multiplier, shifted right each step
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [SH_W-1:0]   step_q,   step_d;
    logic [ADR_W-1:0]  mul_adr_q, mul_adr_d;
    logic              wr_ena_q,  wr_ena_d;
    logic [ADR_W-1:0]  wr_adr_q,  wr_adr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              br_take_q, br_take_d;
    logic [CNT_W-1:0]  br_cnt_q,  br_cnt_d;
    logic [3:0]        flags_q,   flags_d;  // {see, gt, lt, eq}
    logic              haz_q;

    logic              accept;
    logic              do_wr;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] partial;

    assign in_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        step_d    = step_q;
        mul_adr_d = mul_adr_q;
        wr_ena_d  = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
        br_take_d = 1'b0;
        br_cnt_d  = br_cnt_q;
        flags_d   = flags_q;
        do_wr     = 1'b0;
        res       = '0;
        // Accumulator after folding in the current multiplier bit.
        partial   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_e'(op_i))
                        OP_ADD: begin do_wr = 1'b1; res = a_i + b_i; end
                        OP_MOV: begin do_wr = 1'b1; res = b_i; end
                        OP_OR:  begin do_wr = 1'b1; res = a_i | b_i; end
                        OP_AND: begin do_wr = 1'b1; res = a_i & b_i; end
                        OP_INC: begin do_wr = 1'b1; res = b_i + DATA_W'(1); end
                        OP_DEC: begin do_wr = 1'b1; res = b_i - DATA_W'(1); end
                        OP_SUB: begin do_wr = 1'b1; res = a_i - b_i; end
                        OP_SHL: begin do_wr = 1'b1; res = a_i << b_i[SH_W-1:0]; end
                        OP_SHR: begin do_wr = 1'b1; res = a_i >> b_i[SH_W-1:0]; end
                        OP_CMP: flags_d[2:0] = {a_i > b_i, a_i < b_i, a_i == b_i};
                        OP_SEE: flags_d[3] = (a_i[4:0] == b_i[4:0]) && (a_i < b_i);
                        OP_JMP: begin br_take_d = 1'b1; br_cnt_d = cnt_i; end
                        OP_JN: begin
                            if (flags_q[2]) begin br_take_d = 1'b1; br_cnt_d = cnt_i; end
                        end
                        OP_JR: begin
                            if (flags_q[3]) begin br_take_d = 1'b1; br_cnt_d = cnt_i; end
                        end
                        OP_END: state_d = ST_HALT;
                        OP_MUL: begin
                            // Without a multiplier the op retires as a NOP.
                            if (MUL_EN) begin
                                state_d   = ST_MUL;
                                mcand_d   = a_i;
                                mplier_d  = b_i;
                                acc_d     = '0;
                                step_d    = '0;
                                mul_adr_d = adr_i;
                            end
                        end
                        default: ;
                    endcase
                    if (do_wr) begin
                        wr_ena_d  = 1'b1;
                        wr_adr_d  = adr_i;
                        wr_data_d = res;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = partial;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + SH_W'(1);
                if (step_q == LAST_STEP) begin
                    wr_ena_d  = 1'b1;
                    wr_adr_d  = mul_adr_q;
                    wr_data_d = partial;
                    state_d   = ST_IDLE;
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            mul_adr_q <= '0;
            wr_ena_q  <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
            br_take_q <= 1'b0;
            br_cnt_q  <= '0;
            flags_q   <= '0;
            haz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            mul_adr_q <= mul_adr_d;
            wr_ena_q  <= wr_ena_d;
            wr_adr_q  <= wr_adr_d;
            wr_data_q <= wr_data_d;
            br_take_q <= br_take_d;
            br_cnt_q  <= br_cnt_d;
            flags_q   <= flags_d;
            haz_q     <= haz_i;
        end
    end

    assign haz_o     = haz_q;
    assign wr_ena_o  = wr_ena_q;
    assign wr_adr_o  = wr_adr_q;
    assign wr_data_o = wr_data_q;
    assign br_take_o = br_take_q;
    assign br_cnt_o  = br_cnt_q;
    assign flags_o   = flags_q;
    assign busy_o    = (state_q == ST_MUL);
    assign end_pr_o  = (state_q == ST_HALT);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, MUL/reset/END sequences, random ops vs reference model.
// Latency: inputs driven on falling edges, results sampled on the following falling edge.
// Backpressure: every accept wait is bounded; an expired wait is reported as a miscompare.
module tb_alu_exec_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [3:0]  adr = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [11:0] cnt = '0;
    logic        haz_in = 1'b0;
    logic        haz_out;
    logic        wr_ena;
    logic [3:0]  wr_adr;
    logic [15:0] wr_data;
    logic        br_take;
    logic [11:0] br_cnt;
    logic [3:0]  flags;
    logic        busy;
    logic        end_pr;

    int n_vec  = 0;
    int n_fail = 0;
    logic done = 1'b0;

    alu_exec_stage #(.DATA_W(16), .ADR_W(4), .CNT_W(12), .MUL_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .adr_i(adr), .a_i(a), .b_i(b), .cnt_i(cnt),
        .haz_i(haz_in), .haz_o(haz_out),
        .wr_ena_o(wr_ena), .wr_adr_o(wr_adr), .wr_data_o(wr_data),
        .br_take_o(br_take), .br_cnt_o(br_cnt), .flags_o(flags),
        .busy_o(busy), .end_pr_o(end_pr)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one instruction at a falling edge, wait (bounded) for ready, transfer on the next
    // rising edge, and return at the falling edge where a latency-1 result is visible.
    task automatic send(input logic [3:0] s_op, input logic [15:0] s_a, input logic [15:0] s_b,
                        input logic [3:0] s_adr, input logic [11:0] s_cnt);
        int w;
        w = 0;
        op = s_op; a = s_a; b = s_b; adr = s_adr; cnt = s_cnt;
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    // haz_o must repeat haz_i from the previous rising edge, or read 0 after a reset edge.
    logic haz_armed = 1'b0;
    logic rst_e = 1'b0;
    logic haz_e = 1'b0;
    initial forever begin
        @(posedge clk);
        rst_e = rst;
        haz_e = haz_in;
        haz_armed = 1'b1;
    end
    initial forever begin
        @(negedge clk);
        if (haz_armed && !done) chk("haz_delay", 32'(haz_out), rst_e ? 32'd0 : 32'(haz_e));
        haz_in = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  adr;
        logic [11:0] cnt;
        logic        e_wr;
        logic [3:0]  e_adr;
        logic [15:0] e_data;
        logic        e_br;
        logic [11:0] e_cnt;
        logic [3:0]  e_flags;
    } vec_t;

    vec_t tbl[20];

    // Reference model state
    logic        m_see, m_gt, m_lt, m_eq;
    logic [3:0]  m_adr;
    logic [15:0] m_data;

    initial begin
        logic [3:0]  r_op;
        logic [15:0] r_a, r_b, res;
        logic [3:0]  r_adr;
        logic [11:0] r_cnt;
        logic        e_wr, e_br;
        int unsigned prod;
        int          n, bad;

        //          op     a         b         adr   cnt      wr adr   data      br cnt      flags
        tbl[0]  = '{4'h0, 16'hFFFF, 16'h0002, 4'h3, 12'h000, 1, 4'h3, 16'h0001, 0, 12'h000, 4'b0000};
        tbl[1]  = '{4'h1, 16'hDEAD, 16'h1234, 4'h5, 12'h000, 1, 4'h5, 16'h1234, 0, 12'h000, 4'b0000};
        tbl[2]  = '{4'h2, 16'h0005, 16'h0009, 4'h0, 12'h000, 0, 4'h5, 16'h1234, 0, 12'h000, 4'b0010};
        tbl[3]  = '{4'h7, 16'h0000, 16'h0000, 4'h0, 12'h040, 0, 4'h5, 16'h1234, 0, 12'h000, 4'b0010};
        tbl[4]  = '{4'h2, 16'h0009, 16'h0005, 4'h0, 12'h000, 0, 4'h5, 16'h1234, 0, 12'h000, 4'b0100};
        tbl[5]  = '{4'h7, 16'h0000, 16'h0000, 4'h0, 12'h040, 0, 4'h5, 16'h1234, 1, 12'h040, 4'b0100};
        tbl[6]  = '{4'h3, 16'h0021, 16'h0041, 4'h0, 12'h000, 0, 4'h5, 16'h1234, 0, 12'h000, 4'b1100};
        tbl[7]  = '{4'hB, 16'h0000, 16'h0000, 4'h0, 12'h005, 0, 4'h5, 16'h1234, 1, 12'h005, 4'b1100};
        tbl[8]  = '{4'h3, 16'h0041, 16'h0041, 4'h0, 12'h000, 0, 4'h5, 16'h1234, 0, 12'h000, 4'b0100};
        tbl[9]  = '{4'hB, 16'h0000, 16'h0000, 4'h0, 12'h005, 0, 4'h5, 16'h1234, 0, 12'h000, 4'b0100};
        tbl[10] = '{4'h6, 16'h0000, 16'h0000, 4'h0, 12'hABC, 0, 4'h5, 16'h1234, 1, 12'hABC, 4'b0100};
        tbl[11] = '{4'h4, 16'hF0F0, 16'h0FF0, 4'h1, 12'h000, 1, 4'h1, 16'hFFF0, 0, 12'h000, 4'b0100};
        tbl[12] = '{4'h5, 16'hF0F0, 16'h0FF0, 4'h2, 12'h000, 1, 4'h2, 16'h00F0, 0, 12'h000, 4'b0100};
        tbl[13] = '{4'h8, 16'h0000, 16'hFFFF, 4'h4, 12'h000, 1, 4'h4, 16'h0000, 0, 12'h000, 4'b0100};
        tbl[14] = '{4'h9, 16'h0000, 16'h0000, 4'h6, 12'h000, 1, 4'h6, 16'hFFFF, 0, 12'h000, 4'b0100};
        tbl[15] = '{4'hC, 16'h0003, 16'h0005, 4'h8, 12'h000, 1, 4'h8, 16'hFFFE, 0, 12'h000, 4'b0100};
        tbl[16] = '{4'hE, 16'h0001, 16'h0013, 4'h9, 12'h000, 1, 4'h9, 16'h0008, 0, 12'h000, 4'b0100};
        tbl[17] = '{4'hF, 16'h8000, 16'h00FF, 4'hA, 12'h000, 1, 4'hA, 16'h0001, 0, 12'h000, 4'b0100};
        tbl[18] = '{4'h2, 16'h0007, 16'h0007, 4'h0, 12'h000, 0, 4'hA, 16'h0001, 0, 12'h000, 4'b0001};
        tbl[19] = '{4'h7, 16'h0000, 16'h0000, 4'h0, 12'h040, 0, 4'hA, 16'h0001, 0, 12'h000, 4'b0001};

        // ---- reset ----
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_during_reset", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready",   32'(in_ready), 32'd1);
        chk("rst_wr_ena",  32'(wr_ena),   32'd0);
        chk("rst_wr_adr",  32'(wr_adr),   32'd0);
        chk("rst_wr_data", 32'(wr_data),  32'd0);
        chk("rst_br_take", 32'(br_take),  32'd0);
        chk("rst_br_cnt",  32'(br_cnt),   32'd0);
        chk("rst_flags",   32'(flags),    32'd0);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_end_pr",  32'(end_pr),   32'd0);
        @(negedge clk);

        // ---- directed table ----
        for (int i = 0; i < 20; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].adr, tbl[i].cnt);
            chk($sformatf("tbl%0d_wr_ena", i),  32'(wr_ena),  32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_wr_adr", i),  32'(wr_adr),  32'(tbl[i].e_adr));
            chk($sformatf("tbl%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_br_take", i), 32'(br_take), 32'(tbl[i].e_br));
            if (tbl[i].e_br) chk($sformatf("tbl%0d_br_cnt", i), 32'(br_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_flags", i),   32'(flags),   32'(tbl[i].e_flags));
            @(negedge clk);
            chk($sformatf("tbl%0d_idle_wr", i),    32'(wr_ena),  32'd0);
            chk($sformatf("tbl%0d_idle_br", i),    32'(br_take), 32'd0);
            chk($sformatf("tbl%0d_idle_flags", i), 32'(flags),   32'(tbl[i].e_flags));
        end

        // ---- MUL 300*300 with an ADD held valid behind it ----
        send(4'hD, 16'd300, 16'd300, 4'h7, 12'h000);
        op = 4'h0; a = 16'h0001; b = 16'h0002; adr = 4'hB; in_valid = 1'b1;
        n = 0; bad = 0;
        while (!in_ready && n < 40) begin
            if (wr_ena || !busy) bad++;
            n++;
            @(negedge clk);
        end
        chk("mul_stall_cycles", 32'(n),       32'd16);
        chk("mul_during",       32'(bad),     32'd0);
        chk("mul_wr_ena",       32'(wr_ena),  32'd1);
        chk("mul_wr_adr",       32'(wr_adr),  32'd7);
        chk("mul_wr_data",      32'(wr_data), 32'h5F90);
        chk("mul_busy_done",    32'(busy),    32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("add_after_mul_ena",  32'(wr_ena),  32'd1);
        chk("add_after_mul_adr",  32'(wr_adr),  32'hB);
        chk("add_after_mul_data", 32'(wr_data), 32'h0003);

        // ---- reset during MUL ----
        send(4'hD, 16'h1234, 16'h5678, 4'h9, 12'h000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("mulrst_ready_in_reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mulrst_busy",    32'(busy),     32'd0);
        chk("mulrst_ready",   32'(in_ready), 32'd1);
        chk("mulrst_wr_ena",  32'(wr_ena),   32'd0);
        chk("mulrst_wr_data", 32'(wr_data),  32'd0);
        chk("mulrst_flags",   32'(flags),    32'd0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_ena) n++;
        end
        chk("mulrst_no_write", 32'(n), 32'd0);
        m_see = 0; m_gt = 0; m_lt = 0; m_eq = 0; m_adr = '0; m_data = '0;

        // ---- random ops against the reference model ----
        for (int it = 0; it < 250; it++) begin
            r_op = 4'($urandom_range(0, 15));
            if (r_op == 4'hA) r_op = 4'h2;
            r_a = 16'($urandom);
            r_b = 16'($urandom);
            r_adr = 4'($urandom);
            r_cnt = 12'($urandom);
            if ($urandom_range(0, 3) == 0) r_b = r_a;
            if ($urandom_range(0, 3) == 0) begin
                r_a = 16'($urandom_range(0, 255));
                r_b = r_a + 16'(32 * $urandom_range(0, 3));
            end
            e_wr = 0; e_br = 0; res = '0;
            case (r_op)
                4'h0: begin e_wr = 1; res = r_a + r_b; end
                4'h1: begin e_wr = 1; res = r_b; end
                4'h4: begin e_wr = 1; res = r_a | r_b; end
                4'h5: begin e_wr = 1; res = r_a & r_b; end
                4'h8: begin e_wr = 1; res = r_b + 16'd1; end
                4'h9: begin e_wr = 1; res = r_b - 16'd1; end
                4'hC: begin e_wr = 1; res = r_a - r_b; end
                4'hD: begin e_wr = 1; prod = 32'(r_a) * 32'(r_b); res = prod[15:0]; end
                4'hE: begin e_wr = 1; res = r_a << (r_b & 16'h000F); end
                4'hF: begin e_wr = 1; res = r_a >> (r_b & 16'h000F); end
                4'h6: e_br = 1;
                4'h7: e_br = m_gt;
                4'hB: e_br = m_see;
                default: ;
            endcase
            send(r_op, r_a, r_b, r_adr, r_cnt);
            if (r_op == 4'hD) begin
                n = 0;
                while (!in_ready && n < 40) begin n++; @(negedge clk); end
                chk("rnd_mul_cycles", 32'(n), 32'd16);
            end
            if (r_op == 4'h2) begin
                m_gt = (r_a > r_b); m_lt = (r_a < r_b); m_eq = (r_a == r_b);
            end
            if (r_op == 4'h3) m_see = ((r_a & 16'h001F) == (r_b & 16'h001F)) && (r_a < r_b);
            if (e_wr) begin m_adr = r_adr; m_data = res; end
            chk($sformatf("rnd%0d_op%h_wr_ena", it, r_op), 32'(wr_ena),  32'(e_wr));
            chk($sformatf("rnd%0d_op%h_wr_adr", it, r_op), 32'(wr_adr),  32'(m_adr));
            chk($sformatf("rnd%0d_op%h_wr_dat", it, r_op), 32'(wr_data), 32'(m_data));
            chk($sformatf("rnd%0d_op%h_br", it, r_op),     32'(br_take), 32'(e_br));
            if (e_br) chk($sformatf("rnd%0d_br_cnt", it),  32'(br_cnt),  32'(r_cnt));
            chk($sformatf("rnd%0d_op%h_flags", it, r_op),  32'(flags),   32'({m_see, m_gt, m_lt, m_eq}));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("rnd_idle_wr",    32'(wr_ena),  32'd0);
                chk("rnd_idle_br",    32'(br_take), 32'd0);
                chk("rnd_idle_flags", 32'(flags),   32'({m_see, m_gt, m_lt, m_eq}));
            end
        end

        // ---- END, then a held ADD that must never be taken ----
        send(4'hA, 16'h0000, 16'h0000, 4'h0, 12'h000);
        chk("end_pr",       32'(end_pr),   32'd1);
        chk("end_ready",    32'(in_ready), 32'd0);
        chk("end_no_write", 32'(wr_ena),   32'd0);
        op = 4'h0; a = 16'h0001; b = 16'h0001; adr = 4'h1; in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!end_pr || in_ready || wr_ena || busy) bad++;
        end
        chk("halt_sticky", 32'(bad), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
